vend_sequencer: RTL

VEND_SEQUENCER -- requirements
Module: vend_sequencer

---
 rtl/vend_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/vend_sequencer.sv
// Vending sequencer: collects 5/10 coins, dispenses item A or B, then returns change one 5-unit pulse at a time.
// Latency: every response is registered and appears one cycle after the input that causes it is sampled.
// Backpressure: disp_req is held until disp_ready is sampled; coins offered while busy or over the cap are rejected.
module vend_sequencer #(
    parameter int PRICE_A = 15,
    parameter int PRICE_B = 20,
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] coin,
    input  logic [1:0] sel,
    input  logic       disp_ready,
    output logic       disp_req,
    output logic       disp_item,
    output logic       change_pulse,
    output logic       reject,
    output logic [4:0] credit,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [4:0]    credit_nxt;
    logic          item_nxt;
    logic          reject_nxt;
    logic          pulse_nxt;

    logic [4:0]    coin_amt;
    logic          coin_some;
    logic          coin_valid;
    logic [4:0]    room;
    logic [4:0]    price_sel;

    // Coin decode and headroom; the cap is checked against remaining room so the add never overflows 5 bits.
    always_comb begin
        coin_amt   = {1'b0, coin};
        coin_some  = (coin != 4'd0);
        coin_valid = (coin == 4'd5) || (coin == 4'd10);
        room       = 5'd30 - credit;
        price_sel  = (sel == 2'b10) ? 5'(PRICE_B) : 5'(PRICE_A);
    end

    // Next-state and next-output logic; any non-5/10 coin is refused regardless of state.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        credit_nxt = credit;
        item_nxt   = disp_item;
        reject_nxt = coin_some && !coin_valid;
        pulse_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (coin_valid) begin
                    credit_nxt = coin_amt;
                    timer_nxt  = '0;
                    state_nxt  = COLLECT;
                end
            end

            COLLECT: begin
                if (sel != 2'b00) begin
                    // A selection wins over a same-cycle coin, which is refused.
                    timer_nxt = '0;
                    if (coin_some) reject_nxt = 1'b1;
                    if (sel == 2'b11) begin
                        state_nxt = CHANGE;
                    end else if (credit >= price_sel) begin
                        credit_nxt = credit - price_sel;
                        item_nxt   = sel[1];
                        state_nxt  = DISPENSE;
                    end
                end else if (coin_some) begin
                    timer_nxt = '0;
                    if (coin_valid) begin
                        if (coin_amt > room) reject_nxt = 1'b1;
                        else                 credit_nxt = credit + coin_amt;
                    end
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    timer_nxt = '0;
                    state_nxt = CHANGE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end

            DISPENSE: begin
                if (coin_some) reject_nxt = 1'b1;
                if (disp_ready) state_nxt = (credit != 5'd0) ? CHANGE : IDLE;
            end

            CHANGE: begin
                if (coin_some) reject_nxt = 1'b1;
                if (credit >= 5'd5) begin
                    credit_nxt = credit - 5'd5;
                    pulse_nxt  = 1'b1;
                    // Leave as the last 5 units go out so the pulse count equals entry credit / 5.
                    if (credit == 5'd5) state_nxt = IDLE;
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // State, timer and all outputs registered; reset clears everything including pending change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            credit       <= 5'd0;
            disp_item    <= 1'b0;
            disp_req     <= 1'b0;
            change_pulse <= 1'b0;
            reject       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            credit       <= credit_nxt;
            disp_item    <= item_nxt;
            disp_req     <= (state_nxt == DISPENSE);
            change_pulse <= pulse_nxt;
            reject       <= reject_nxt;
            busy         <= (state_nxt == DISPENSE) || (state_nxt == CHANGE);
        end
    end

endmodule
